arbitro_gerenciador_ativos: RTL and testbench

//  Shares the active-node manager among NUM_REQ requesters (neighbour-expansion units, min-finder).

---
 rtl/ga_pkg.sv | 23 ++
 rtl/rr_seletor.sv | 31 +++
 rtl/arbitro_gerenciador_ativos.sv | 191 +++++++++++++++++++
 tb/tb_arbitro_gerenciador_ativos.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ga_pkg.sv
// Shared types and defaults for the active-node manager arbiter.
package ga_pkg;

   localparam int unsigned NUM_REQ_DEF         = 4;
   localparam int unsigned ADR_WIDTH_DEF       = 5;
   localparam int unsigned DISTANCIA_WIDTH_DEF = 5;
   localparam int unsigned CUSTO_WIDTH_DEF     = 4;
   localparam int unsigned TIMEOUT_CYCLES_DEF  = 64;

   typedef enum logic [2:0] {
      ST_IDLE          = 3'd0,
      ST_EMITIR        = 3'd1,
      ST_ESPERA_INICIO = 3'd2,
      ST_ESPERA_FIM    = 3'd3,
      ST_CONCLUIR      = 3'd4
   } estado_t;

   // Width of a grant index; never below one bit.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/rr_seletor.sv
// Round-robin selector: request vector plus start pointer to one-hot grant and index.
module rr_seletor
   import ga_pkg::*;
#(
   parameter  int unsigned NUM_REQ = NUM_REQ_DEF,
   localparam int unsigned IW      = idx_width(NUM_REQ)
)(
   input  logic [NUM_REQ-1:0] req_in,
   input  logic [IW-1:0]      ptr_in,
   output logic [NUM_REQ-1:0] grant_c,
   output logic [IW-1:0]      idx_c,
   output logic               valido_c
);

   // Scan from the pointer upward, wrapping; first hit wins.
   always_comb begin
      logic [IW-1:0] cand;
      grant_c  = '0;
      idx_c    = '0;
      valido_c = 1'b0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         cand = IW'((32'(ptr_in) + k) % NUM_REQ);
         if (!valido_c && req_in[cand]) begin
            valido_c       = 1'b1;
            grant_c[cand]  = 1'b1;
            idx_c          = cand;
         end
      end
   end

endmodule

// File: rtl/arbitro_gerenciador_ativos.sv
// Serialises atualizar/desativar commands from NUM_REQ requesters onto the active-node manager.
// Optional handshake watchdog enabled by defining GA_TIMEOUT_EN.
module arbitro_gerenciador_ativos
   import ga_pkg::*;
#(
   parameter int unsigned NUM_REQ         = NUM_REQ_DEF,
   parameter int unsigned ADR_WIDTH       = ADR_WIDTH_DEF,
   parameter int unsigned DISTANCIA_WIDTH = DISTANCIA_WIDTH_DEF,
   parameter int unsigned CUSTO_WIDTH     = CUSTO_WIDTH_DEF,
   parameter int unsigned TIMEOUT_CYCLES  = TIMEOUT_CYCLES_DEF
)(
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic [NUM_REQ-1:0]                 req_atualizar_in,
   input  logic [NUM_REQ-1:0]                 req_desativar_in,
   input  logic [NUM_REQ*ADR_WIDTH-1:0]       req_endereco_in,
   input  logic [NUM_REQ*ADR_WIDTH-1:0]       req_anterior_in,
   input  logic [NUM_REQ*CUSTO_WIDTH-1:0]     req_menor_vizinho_in,
   input  logic [NUM_REQ*DISTANCIA_WIDTH-1:0] req_distancia_in,
   output logic [NUM_REQ-1:0]                 ack_out,
   output logic [NUM_REQ-1:0]                 erro_out,
   input  logic                               ga_ocupado_in,
   output logic                               arb_atualizar_out,
   output logic                               arb_desativar_out,
   output logic [ADR_WIDTH-1:0]               arb_endereco_out,
   output logic [ADR_WIDTH-1:0]               arb_anterior_out,
   output logic [CUSTO_WIDTH-1:0]             arb_menor_vizinho_out,
   output logic [DISTANCIA_WIDTH-1:0]         arb_distancia_out,
   output logic                               arb_ocupado_out
);

   localparam int unsigned IW = idx_width(NUM_REQ);

   logic [NUM_REQ-1:0]         vec_de_c, vec_at_c, oh_de_c, oh_at_c;
   logic [IW-1:0]              idx_de_c, idx_at_c, sel_idx_c;
   logic                       val_de_c, val_at_c, timeout_c;

   estado_t                    estado_q, estado_d;
   logic [IW-1:0]              ptr_q, ptr_d, gnt_idx_q, gnt_idx_d;
   logic [NUM_REQ-1:0]         gnt_oh_q, gnt_oh_d, ack_q, ack_d;
   logic                       atualizar_q, atualizar_d, desativar_q, desativar_d;
   logic                       ocupado_q, ocupado_d;
   logic [ADR_WIDTH-1:0]       endereco_q, endereco_d, anterior_q, anterior_d;
   logic [CUSTO_WIDTH-1:0]     custo_q, custo_d;
   logic [DISTANCIA_WIDTH-1:0] distancia_q, distancia_d;

   // A requester with both bits set is treated purely as desativar.
   assign vec_de_c  = req_desativar_in;
   assign vec_at_c  = req_atualizar_in & ~req_desativar_in;
   assign sel_idx_c = val_de_c ? idx_de_c : idx_at_c;

   rr_seletor #(.NUM_REQ(NUM_REQ)) u_sel_de (
      .req_in(vec_de_c), .ptr_in(ptr_q), .grant_c(oh_de_c), .idx_c(idx_de_c), .valido_c(val_de_c)
   );

   rr_seletor #(.NUM_REQ(NUM_REQ)) u_sel_at (
      .req_in(vec_at_c), .ptr_in(ptr_q), .grant_c(oh_at_c), .idx_c(idx_at_c), .valido_c(val_at_c)
   );

`ifdef GA_TIMEOUT_EN
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0]      cnt_q, cnt_d;
   logic [NUM_REQ-1:0] erro_q, erro_d;
   assign timeout_c = (cnt_q == TW'(TIMEOUT_CYCLES - 1));
   assign erro_out  = erro_q;
`else
   assign timeout_c = 1'b0;
   assign erro_out  = '0;
`endif

   always_comb begin
      estado_d    = estado_q;
      ptr_d       = ptr_q;
      gnt_idx_d   = gnt_idx_q;
      gnt_oh_d    = gnt_oh_q;
      endereco_d  = endereco_q;
      anterior_d  = anterior_q;
      custo_d     = custo_q;
      distancia_d = distancia_q;
      atualizar_d = 1'b0;
      desativar_d = 1'b0;
      ack_d       = '0;
`ifdef GA_TIMEOUT_EN
      erro_d      = '0;
`endif
      unique case (estado_q)
         ST_IDLE: begin
            if (!ga_ocupado_in && (val_de_c || val_at_c)) begin
               gnt_idx_d   = sel_idx_c;
               gnt_oh_d    = val_de_c ? oh_de_c : oh_at_c;
               endereco_d  = req_endereco_in[32'(sel_idx_c)*ADR_WIDTH +: ADR_WIDTH];
               anterior_d  = req_anterior_in[32'(sel_idx_c)*ADR_WIDTH +: ADR_WIDTH];
               custo_d     = req_menor_vizinho_in[32'(sel_idx_c)*CUSTO_WIDTH +: CUSTO_WIDTH];
               distancia_d = req_distancia_in[32'(sel_idx_c)*DISTANCIA_WIDTH +: DISTANCIA_WIDTH];
               desativar_d = val_de_c;
               atualizar_d = !val_de_c;
               estado_d    = ST_EMITIR;
            end
         end
         ST_EMITIR: estado_d = ST_ESPERA_INICIO;
         ST_ESPERA_INICIO: begin
            if (ga_ocupado_in) begin
               estado_d = ST_ESPERA_FIM;
            end else if (timeout_c) begin
               estado_d = ST_CONCLUIR;
               ack_d    = gnt_oh_q;
`ifdef GA_TIMEOUT_EN
               erro_d   = gnt_oh_q;
`endif
            end
         end
         ST_ESPERA_FIM: begin
            if (!ga_ocupado_in) begin
               estado_d = ST_CONCLUIR;
               ack_d    = gnt_oh_q;
            end else if (timeout_c) begin
               estado_d = ST_CONCLUIR;
               ack_d    = gnt_oh_q;
`ifdef GA_TIMEOUT_EN
               erro_d   = gnt_oh_q;
`endif
            end
         end
         ST_CONCLUIR: begin
            ptr_d    = (32'(gnt_idx_q) == NUM_REQ - 1) ? '0 : IW'(32'(gnt_idx_q) + 32'd1);
            estado_d = ST_IDLE;
         end
         default: estado_d = ST_IDLE;
      endcase
      ocupado_d = (estado_d != ST_IDLE);
   end

`ifdef GA_TIMEOUT_EN
   // Watchdog counts only while parked in a wait state; any state change clears it.
   always_comb begin
      cnt_d = '0;
      if ((estado_q == ST_ESPERA_INICIO || estado_q == ST_ESPERA_FIM) && estado_d == estado_q)
         cnt_d = cnt_q + TW'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         erro_q <= '0;
      end else begin
         cnt_q  <= cnt_d;
         erro_q <= erro_d;
      end
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         estado_q    <= ST_IDLE;
         ptr_q       <= '0;
         gnt_idx_q   <= '0;
         gnt_oh_q    <= '0;
         ack_q       <= '0;
         atualizar_q <= 1'b0;
         desativar_q <= 1'b0;
         ocupado_q   <= 1'b0;
         endereco_q  <= '0;
         anterior_q  <= '0;
         custo_q     <= '0;
         distancia_q <= '0;
      end else begin
         estado_q    <= estado_d;
         ptr_q       <= ptr_d;
         gnt_idx_q   <= gnt_idx_d;
         gnt_oh_q    <= gnt_oh_d;
         ack_q       <= ack_d;
         atualizar_q <= atualizar_d;
         desativar_q <= desativar_d;
         ocupado_q   <= ocupado_d;
         endereco_q  <= endereco_d;
         anterior_q  <= anterior_d;
         custo_q     <= custo_d;
         distancia_q <= distancia_d;
      end
   end

   assign ack_out               = ack_q;
   assign arb_atualizar_out     = atualizar_q;
   assign arb_desativar_out     = desativar_q;
   assign arb_endereco_out      = endereco_q;
   assign arb_anterior_out      = anterior_q;
   assign arb_menor_vizinho_out = custo_q;
   assign arb_distancia_out     = distancia_q;
   assign arb_ocupado_out       = ocupado_q;

endmodule

// File: tb/tb_arbitro_gerenciador_ativos.sv
// Directed bench for arbitro_gerenciador_ativos with a simple busy-manager model.
module tb_arbitro_gerenciador_ativos;

   localparam int unsigned N  = 4;
   localparam int unsigned AW = 5;
   localparam int unsigned DW = 5;
   localparam int unsigned CW = 4;
   localparam int unsigned TO = 16;
   localparam int unsigned MGR_BUSY = 2;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N-1:0]    req_at, req_de;
   logic [N*AW-1:0] req_end, req_ant;
   logic [N*CW-1:0] req_cus;
   logic [N*DW-1:0] req_dis;
   logic [N-1:0]    ack_out, erro_out;
   logic            ga_ocupado_in;
   logic            arb_atualizar_out, arb_desativar_out, arb_ocupado_out;
   logic [AW-1:0]   arb_endereco_out, arb_anterior_out;
   logic [CW-1:0]   arb_menor_vizinho_out;
   logic [DW-1:0]   arb_distancia_out;

   logic            force_busy;
   logic            mgr_stuck;
   int unsigned     mgr_cnt;

   int checks = 0;
   int errors = 0;
   int ordem[$];

   always #5 clk = ~clk;

   arbitro_gerenciador_ativos #(
      .NUM_REQ(N), .ADR_WIDTH(AW), .DISTANCIA_WIDTH(DW), .CUSTO_WIDTH(CW), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .req_atualizar_in(req_at), .req_desativar_in(req_de),
      .req_endereco_in(req_end), .req_anterior_in(req_ant),
      .req_menor_vizinho_in(req_cus), .req_distancia_in(req_dis),
      .ack_out(ack_out), .erro_out(erro_out),
      .ga_ocupado_in(ga_ocupado_in),
      .arb_atualizar_out(arb_atualizar_out), .arb_desativar_out(arb_desativar_out),
      .arb_endereco_out(arb_endereco_out), .arb_anterior_out(arb_anterior_out),
      .arb_menor_vizinho_out(arb_menor_vizinho_out), .arb_distancia_out(arb_distancia_out),
      .arb_ocupado_out(arb_ocupado_out)
   );

   // Manager model: busy for MGR_BUSY cycles starting the cycle after a command pulse.
   always @(posedge clk) begin
      if (!rst_n)
         mgr_cnt <= 0;
      else if (arb_atualizar_out || arb_desativar_out)
         mgr_cnt <= MGR_BUSY;
      else if (mgr_cnt != 0 && !mgr_stuck)
         mgr_cnt <= mgr_cnt - 1;
   end
   assign ga_ocupado_in = force_busy || (mgr_cnt != 0);

   typedef struct {
      int            idx;
      logic          at;
      logic          de;
      logic [AW-1:0] ende;
      logic [AW-1:0] ant;
      logic [CW-1:0] cus;
      logic [DW-1:0] dis;
      logic          exp_de;
      logic [N-1:0]  exp_ack;
   } vec_t;

   vec_t tab[4];

   task automatic chk(input string nome, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nome, act, exp);
      end
   endtask

   function automatic logic [31:0] todas_saidas();
      return 32'({ack_out, erro_out, arb_atualizar_out, arb_desativar_out, arb_endereco_out,
                  arb_anterior_out, arb_menor_vizinho_out, arb_distancia_out, arb_ocupado_out});
   endfunction

   task automatic espera_pulso(output bit ok);
      ok = 1'b0;
      for (int c = 0; c < 20 && !ok; c++) begin
         @(negedge clk);
         if (arb_atualizar_out || arb_desativar_out) ok = 1'b1;
      end
      chk("pulso_visto", 32'(ok), 32'd1);
   endtask

   // Collect n acks in order; non-continuous requesters drop their request on ack.
   task automatic coleta(input int n, input bit continuo);
      int got = 0;
      for (int c = 0; c < n * 20 && got < n; c++) begin
         @(negedge clk);
         if (ack_out != '0) begin
            chk("ack_onehot", 32'($countones(ack_out)), 32'd1);
            for (int j = 0; j < N; j++) begin
               if (ack_out[j]) begin
                  ordem.push_back(j);
                  if (!continuo) begin
                     req_at[j] = 1'b0;
                     req_de[j] = 1'b0;
                  end
               end
            end
            got++;
         end
      end
      chk("coleta_qtd", 32'(got), 32'(n));
   endtask

   initial begin
      bit ok;
      int npulse, nack, c;
      logic [N-1:0] ack_visto, erro_visto;

      tab[0] = '{idx:2, at:1'b1, de:1'b0, ende:5'd9,  ant:5'd5,  cus:4'd3,  dis:5'd7,  exp_de:1'b0, exp_ack:4'b0100};
      tab[1] = '{idx:0, at:1'b0, de:1'b1, ende:5'd31, ant:5'd0,  cus:4'd15, dis:5'd0,  exp_de:1'b1, exp_ack:4'b0001};
      tab[2] = '{idx:3, at:1'b1, de:1'b1, ende:5'd17, ant:5'd4,  cus:4'd8,  dis:5'd31, exp_de:1'b1, exp_ack:4'b1000};
      tab[3] = '{idx:1, at:1'b1, de:1'b0, ende:5'd0,  ant:5'd31, cus:4'd1,  dis:5'd16, exp_de:1'b0, exp_ack:4'b0010};

      rst_n = 1'b0; force_busy = 1'b0; mgr_stuck = 1'b0;
      req_at = '0; req_de = '0; req_end = '0; req_ant = '0; req_cus = '0; req_dis = '0;
      repeat (3) @(negedge clk);
      chk("reset_saidas", todas_saidas(), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_ocupado", 32'(arb_ocupado_out), 32'd0);

      // Four requesters held continuously: strict rotation from pointer 0.
      ordem.delete();
      req_at = '1;
      coleta(12, 1'b1);
      req_at = '0;
      for (int k = 0; k < 12; k++)
         if (k < ordem.size()) chk($sformatf("rr_seq_%0d", k), 32'(ordem[k]), 32'(k % 4));

      // Single-requester command table with decoy payloads on the other lanes.
      for (int v = 0; v < 4; v++) begin
         for (int j = 0; j < N; j++) begin
            req_end[j*AW +: AW] = AW'(j + 20);
            req_ant[j*AW +: AW] = AW'(j + 10);
            req_cus[j*CW +: CW] = CW'(j + 11);
            req_dis[j*DW +: DW] = DW'(j + 24);
         end
         req_end[tab[v].idx*AW +: AW] = tab[v].ende;
         req_ant[tab[v].idx*AW +: AW] = tab[v].ant;
         req_cus[tab[v].idx*CW +: CW] = tab[v].cus;
         req_dis[tab[v].idx*DW +: DW] = tab[v].dis;
         req_at[tab[v].idx] = tab[v].at;
         req_de[tab[v].idx] = tab[v].de;
         npulse = 0;
         ok = 1'b0;
         for (int k = 0; k < 60 && !ok; k++) begin
            @(negedge clk);
            if (arb_atualizar_out || arb_desativar_out) begin
               npulse++;
               chk($sformatf("v%0d_tipo_de", v), 32'(arb_desativar_out), 32'(tab[v].exp_de));
               chk($sformatf("v%0d_tipo_at", v), 32'(arb_atualizar_out), 32'(!tab[v].exp_de));
               chk($sformatf("v%0d_end", v), 32'(arb_endereco_out), 32'(tab[v].ende));
               chk($sformatf("v%0d_ant", v), 32'(arb_anterior_out), 32'(tab[v].ant));
               chk($sformatf("v%0d_cus", v), 32'(arb_menor_vizinho_out), 32'(tab[v].cus));
               chk($sformatf("v%0d_dis", v), 32'(arb_distancia_out), 32'(tab[v].dis));
            end
            if (ack_out != '0) begin
               ok = 1'b1;
               chk($sformatf("v%0d_ack", v), 32'(ack_out), 32'(tab[v].exp_ack));
               chk($sformatf("v%0d_erro", v), 32'(erro_out), 32'd0);
            end
         end
         chk($sformatf("v%0d_ack_visto", v), 32'(ok), 32'd1);
         chk($sformatf("v%0d_pulsos", v), 32'(npulse), 32'd1);
         req_at = '0; req_de = '0;
         nack = 0;
         repeat (4) begin
            @(negedge clk);
            if (ack_out != '0) nack++;
         end
         chk($sformatf("v%0d_ack_extra", v), 32'(nack), 32'd0);
         chk($sformatf("v%0d_end_estavel", v), 32'(arb_endereco_out), 32'(tab[v].ende));
      end

      // Desativar beats atualizar; atualizar rotates from grant+1.
      ordem.delete();
      req_at = 4'b1001; req_de = 4'b0010;
      coleta(3, 1'b0);
      if (ordem.size() == 3) begin
         chk("ordem_0", 32'(ordem[0]), 32'd1);
         chk("ordem_1", 32'(ordem[1]), 32'd3);
         chk("ordem_2", 32'(ordem[2]), 32'd0);
      end

      // No grant while the manager is busy; pulse the cycle after it frees up.
      force_busy = 1'b1;
      req_at[0] = 1'b1;
      npulse = 0;
      repeat (10) begin
         @(negedge clk);
         if (arb_atualizar_out || arb_desativar_out || arb_ocupado_out) npulse++;
      end
      chk("busy_sem_grant", 32'(npulse), 32'd0);
      force_busy = 1'b0;
      @(negedge clk);
      chk("pulso_pos_busy", 32'(arb_atualizar_out), 32'd1);
      ordem.delete();
      coleta(1, 1'b0);
      if (ordem.size() == 1) chk("ack_pos_busy", 32'(ordem[0]), 32'd0);

      // Manager stuck busy.
      mgr_stuck = 1'b1;
      req_at[2] = 1'b1;
      espera_pulso(ok);
`ifdef GA_TIMEOUT_EN
      c = 0;
      ack_visto = '0; erro_visto = '0;
      for (int k = 1; k <= 40 && c == 0; k++) begin
         @(negedge clk);
         if (ack_out != '0) begin
            c = k; ack_visto = ack_out; erro_visto = erro_out;
         end
      end
      chk("to_ack", 32'(ack_visto), 32'b0100);
      chk("to_erro", 32'(erro_visto), 32'b0100);
      chk("to_latencia", 32'(c), 32'd18);
      req_at[2] = 1'b0;
      mgr_stuck = 1'b0;
      repeat (4) @(negedge clk);
      req_at[2] = 1'b1;
      mgr_stuck = 1'b1;
      espera_pulso(ok);
      repeat (4) @(negedge clk);
`else
      nack = 0;
      ack_visto = '0; erro_visto = '0;
      c = 0;
      repeat (1000) begin
         @(negedge clk);
         if (ack_out != '0) nack++;
      end
      chk("sem_ack_1000", 32'(nack), 32'd0);
`endif

      // Reset while waiting for the manager to finish.
      chk("preso_ocupado", 32'(arb_ocupado_out), 32'd1);
      req_at[0] = 1'b1;
      rst_n = 1'b0;
      #1;
      chk("reset_async", todas_saidas(), 32'd0);
      mgr_stuck = 1'b0;
      nack = 0;
      repeat (2) begin
         @(negedge clk);
         if (ack_out != '0) nack++;
      end
      chk("reset_sem_ack", 32'(nack), 32'd0);
      rst_n = 1'b1;
      ordem.delete();
      coleta(2, 1'b0);
      if (ordem.size() == 2) begin
         chk("pos_reset_0", 32'(ordem[0]), 32'd0);
         chk("pos_reset_1", 32'(ordem[1]), 32'd2);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
